// File: rtl/mul_arb_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mul_arb_if
// Description : Request/response bundle between two requesters and the shared
//               multiplier arbiter.
//               Requester lanes are packed: lane i occupies [i*W +: W].
//               master : requester side (drives requests, accepts responses)
//               slave  : arbiter side (accepts requests, drives responses)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface mul_arb_if #(
   parameter int XLEN = 64,
   parameter int TAGW = 4
);
   logic [1:0]          ReqValid;
   logic [1:0]          ReqReady;
   logic [2*XLEN-1:0]   ReqSrcA;
   logic [2*XLEN-1:0]   ReqSrcB;
   logic [5:0]          ReqFunct3;
   logic [2*TAGW-1:0]   ReqTag;
   logic                Kill;
   logic                RspValid;
   logic                RspReady;
   logic                RspId;
   logic [TAGW-1:0]     RspTag;
   logic [2*XLEN-1:0]   RspProd;

   modport master (
      output ReqValid, ReqSrcA, ReqSrcB, ReqFunct3, ReqTag, Kill, RspReady,
      input  ReqReady, RspValid, RspId, RspTag, RspProd
   );

   modport slave (
      input  ReqValid, ReqSrcA, ReqSrcB, ReqFunct3, ReqTag, Kill, RspReady,
      output ReqReady, RspValid, RspId, RspTag, RspProd
   );
endinterface
`default_nettype wire

// File: rtl/mul_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mul_arb
// Description : Round-robin arbiter/sequencer sharing one two-stage pipelined
//               multiplier between requester 0 (integer pipeline) and
//               requester 1 (coprocessor). Tracks owner/tag of the op held in
//               the multiplier M stage and returns the double-width product on
//               a valid/ready channel. Backpressure stalls the M stage.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               bus (slave)     - request lanes, Kill, response channel
//               MulSrcAE/BE     - operands to multiplier E stage
//               MulFunct3E      - multiply type to multiplier E stage
//               MulStallM       - hold multiplier M-stage registers
//               MulFlushM       - clear multiplier M-stage registers
//               MulProdM        - product from multiplier M stage
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mul_arb #(
   parameter int XLEN = 64,
   parameter int TAGW = 4
) (
   input  wire logic               clk,
   input  wire logic               reset,
   mul_arb_if.slave                bus,
   output logic [XLEN-1:0]         MulSrcAE,
   output logic [XLEN-1:0]         MulSrcBE,
   output logic [2:0]              MulFunct3E,
   output logic                    MulStallM,
   output logic                    MulFlushM,
   input  wire logic [2*XLEN-1:0]  MulProdM
);

   // M-stage occupancy
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                mid_q,   mid_d;
   logic [TAGW-1:0]     mtag_q,  mtag_d;
   logic                prio_q,  prio_d;

   logic                w_mvalid;
   logic                w_rsp_valid;
   logic                w_rsp_fire;
   logic                w_slot_free;
   logic                w_gnt;
   logic                w_accept;
   logic                w_sel;
   logic [TAGW-1:0]     w_gnt_tag;

   //---------------------------------------------------------------------------
   // Grant, handshake and datapath select
   //---------------------------------------------------------------------------
   always_comb begin
      w_mvalid    = (state_q == ST_FULL);
      w_rsp_valid = w_mvalid & ~bus.Kill;
      w_rsp_fire  = w_rsp_valid & bus.RspReady;
      // A response leaving this cycle frees the slot for a back-to-back issue.
      w_slot_free = ~w_mvalid | w_rsp_fire;

      // Tie goes to the round-robin pointer; otherwise the lone valid one.
      // With nothing valid this evaluates to 0.
      if (&bus.ReqValid) begin
         w_gnt = prio_q;
      end else begin
         w_gnt = bus.ReqValid[1];
      end

      w_accept = (|bus.ReqValid) & w_slot_free & ~bus.Kill;

      bus.ReqReady = 2'b00;
      if (w_accept) begin
         bus.ReqReady[w_gnt] = 1'b1;
      end

      // Select parks on lane 0 whenever nothing is being accepted.
      w_sel = w_accept & w_gnt;

      if (w_sel) begin
         MulSrcAE   = bus.ReqSrcA[2*XLEN-1:XLEN];
         MulSrcBE   = bus.ReqSrcB[2*XLEN-1:XLEN];
         MulFunct3E = bus.ReqFunct3[5:3];
         w_gnt_tag  = bus.ReqTag[2*TAGW-1:TAGW];
      end else begin
         MulSrcAE   = bus.ReqSrcA[XLEN-1:0];
         MulSrcBE   = bus.ReqSrcB[XLEN-1:0];
         MulFunct3E = bus.ReqFunct3[2:0];
         w_gnt_tag  = bus.ReqTag[TAGW-1:0];
      end

      // Freeze partial products while a response waits; Kill overrides.
      MulStallM = w_mvalid & ~bus.RspReady & ~bus.Kill;
      MulFlushM = bus.Kill;

      bus.RspValid = w_rsp_valid;
      bus.RspId    = mid_q;
      bus.RspTag   = mtag_q;
      bus.RspProd  = MulProdM;
   end

   //---------------------------------------------------------------------------
   // Next-state
   //---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      mid_d   = mid_q;
      mtag_d  = mtag_q;
      prio_d  = prio_q;

      if (bus.Kill) begin
         // Killed op vanishes; no accept happens in a Kill cycle.
         state_d = ST_EMPTY;
      end else if (w_accept) begin
         state_d = ST_FULL;
         mid_d   = w_gnt;
         mtag_d  = w_gnt_tag;
         prio_d  = ~w_gnt;
      end else if (w_rsp_fire) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         mid_q   <= 1'b0;
         mtag_q  <= '0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mid_q   <= mid_d;
         mtag_q  <= mtag_d;
         prio_q  <= prio_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mul_arb
// Description : Directed self-checking bench for mul_arb, with a small
//               behavioural two-stage multiplier hanging off the Mul* ports.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mul_arb;
   localparam int XLEN = 64;
   localparam int TAGW = 4;

   logic clk = 1'b0;
   logic reset;
   logic [XLEN-1:0]   MulSrcAE, MulSrcBE;
   logic [2:0]        MulFunct3E;
   logic              MulStallM, MulFlushM;
   logic [2*XLEN-1:0] MulProdM;

   int total  = 0;
   int passed = 0;

   mul_arb_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

   mul_arb #(.XLEN(XLEN), .TAGW(TAGW)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .MulSrcAE   (MulSrcAE),
      .MulSrcBE   (MulSrcBE),
      .MulFunct3E (MulFunct3E),
      .MulStallM  (MulStallM),
      .MulFlushM  (MulFlushM),
      .MulProdM   (MulProdM)
   );

   always #5 clk = ~clk;

   // Behavioural multiplier: E operands captured into M regs unless stalled.
   logic [XLEN-1:0] ma, mb;
   logic [2:0]      mf;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ma <= '0; mb <= '0; mf <= '0;
      end else if (MulFlushM) begin
         ma <= '0; mb <= '0; mf <= '0;
      end else if (!MulStallM) begin
         ma <= MulSrcAE; mb <= MulSrcBE; mf <= MulFunct3E;
      end
   end

   function automatic logic [2*XLEN-1:0] mul_model(input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic [2:0] f);
      logic [2*XLEN-1:0] ea, eb;
      ea = (f == 3'b011) ? {{XLEN{1'b0}}, a} : {{XLEN{a[XLEN-1]}}, a};
      eb = (f[1])        ? {{XLEN{1'b0}}, b} : {{XLEN{b[XLEN-1]}}, b};
      return ea * eb;
   endfunction

   assign MulProdM = mul_model(ma, mb, mf);

   task automatic do_reset();
      reset         = 1'b1;
      bus.ReqValid  = 2'b00;
      bus.ReqSrcA   = '0;
      bus.ReqSrcB   = '0;
      bus.ReqFunct3 = '0;
      bus.ReqTag    = '0;
      bus.Kill      = 1'b0;
      bus.RspReady  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      bus.ReqSrcA = {64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD};
      #1;
      total++; if (bus.RspValid !== 1'b0) $display("FAIL reset_rspvalid got %0b exp 0", bus.RspValid); else passed++;
      total++; if (bus.ReqReady !== 2'b00) $display("FAIL reset_reqready got %b exp 00", bus.ReqReady); else passed++;
      total++; if (MulStallM !== 1'b0) $display("FAIL reset_stall got %0b exp 0", MulStallM); else passed++;
      total++; if (MulFlushM !== 1'b0) $display("FAIL reset_flush got %0b exp 0", MulFlushM); else passed++;
      total++; if (MulSrcAE !== 64'hAAAA_BBBB_CCCC_DDDD) $display("FAIL idle_select got %h exp aaaabbbbccccdddd", MulSrcAE); else passed++;
   endtask

   task automatic test_single();
      do_reset();
      @(negedge clk);
      bus.RspReady  = 1'b1;
      bus.ReqValid  = 2'b01;
      bus.ReqSrcA   = {64'd0, 64'd3};
      bus.ReqSrcB   = {64'd0, 64'd5};
      bus.ReqFunct3 = 6'b000_000;
      bus.ReqTag    = 8'h02;
      #1;
      total++; if (bus.ReqReady !== 2'b01) $display("FAIL single_reqready got %b exp 01", bus.ReqReady); else passed++;
      @(negedge clk);
      bus.ReqValid = 2'b00;
      #1;
      total++; if (bus.RspValid !== 1'b1) $display("FAIL single_rspvalid got %0b exp 1", bus.RspValid); else passed++;
      total++; if (bus.RspId !== 1'b0) $display("FAIL single_id got %0b exp 0", bus.RspId); else passed++;
      total++; if (bus.RspTag !== 4'd2) $display("FAIL single_tag got %0d exp 2", bus.RspTag); else passed++;
      total++; if (bus.RspProd !== 128'd15) $display("FAIL single_prod got %h exp 15", bus.RspProd); else passed++;
      @(negedge clk);
      #1;
      total++; if (bus.RspValid !== 1'b0) $display("FAIL single_drain got %0b exp 0", bus.RspValid); else passed++;
   endtask

   task automatic test_round_robin();
      logic [2*XLEN-1:0] exp_prod [2];
      exp_prod[0] = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA};  // -2 * 3
      exp_prod[1] = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE4};  // 7 * -4
      do_reset();
      @(negedge clk);
      bus.RspReady  = 1'b1;
      bus.ReqValid  = 2'b11;
      bus.ReqSrcA   = {64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
      bus.ReqSrcB   = {64'hFFFF_FFFF_FFFF_FFFC, 64'd3};
      bus.ReqFunct3 = 6'b001_001;
      bus.ReqTag    = {4'd9, 4'd1};
      for (int k = 0; k <= 6; k++) begin
         if (k == 6) bus.ReqValid = 2'b00;
         #1;
         if (k < 6) begin
            total++; if (bus.ReqReady !== ((k % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL rr_grant cyc %0d got %b", k, bus.ReqReady); else passed++;
         end
         if (k > 0) begin
            total++; if (bus.RspValid !== 1'b1) $display("FAIL rr_rspvalid cyc %0d got %0b exp 1", k, bus.RspValid); else passed++;
            total++; if (bus.RspId !== 1'((k - 1) % 2)) $display("FAIL rr_id cyc %0d got %0b exp %0d", k, bus.RspId, (k - 1) % 2); else passed++;
            total++; if (bus.RspTag !== (((k - 1) % 2 == 0) ? 4'd1 : 4'd9)) $display("FAIL rr_tag cyc %0d got %0d", k, bus.RspTag); else passed++;
            total++; if (bus.RspProd !== exp_prod[(k - 1) % 2]) $display("FAIL rr_prod cyc %0d got %h exp %h", k, bus.RspProd, exp_prod[(k - 1) % 2]); else passed++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      bus.RspReady  = 1'b0;
      bus.ReqValid  = 2'b01;
      bus.ReqSrcA   = {64'd10, 64'd6};
      bus.ReqSrcB   = {64'd11, 64'd7};
      bus.ReqFunct3 = 6'b000_000;
      bus.ReqTag    = {4'd5, 4'd3};
      #1;
      total++; if (bus.ReqReady !== 2'b01) $display("FAIL bp_issue got %b exp 01", bus.ReqReady); else passed++;
      @(negedge clk);
      // Lane 0 now carries junk; a working stall keeps 6*7 in the M stage.
      bus.ReqValid = 2'b10;
      bus.ReqSrcA  = {64'd10, 64'd100};
      bus.ReqSrcB  = {64'd11, 64'd100};
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (bus.RspValid !== 1'b1) $display("FAIL bp_rspvalid cyc %0d got %0b exp 1", k, bus.RspValid); else passed++;
         total++; if (MulStallM !== 1'b1) $display("FAIL bp_stall cyc %0d got %0b exp 1", k, MulStallM); else passed++;
         total++; if (bus.ReqReady !== 2'b00) $display("FAIL bp_reqready cyc %0d got %b exp 00", k, bus.ReqReady); else passed++;
         total++; if (bus.RspProd !== 128'd42) $display("FAIL bp_prod cyc %0d got %h exp 42", k, bus.RspProd); else passed++;
         @(negedge clk);
      end
      bus.RspReady = 1'b1;
      #1;
      total++; if (bus.ReqReady !== 2'b10) $display("FAIL bp_release_accept got %b exp 10", bus.ReqReady); else passed++;
      total++; if (MulStallM !== 1'b0) $display("FAIL bp_release_stall got %0b exp 0", MulStallM); else passed++;
      total++; if (bus.RspProd !== 128'd42 || bus.RspId !== 1'b0 || bus.RspTag !== 4'd3) $display("FAIL bp_release_rsp got id %0b tag %0d prod %h exp id 0 tag 3 prod 42", bus.RspId, bus.RspTag, bus.RspProd); else passed++;
      @(negedge clk);
      bus.ReqValid = 2'b00;
      #1;
      total++; if (bus.RspValid !== 1'b1 || bus.RspId !== 1'b1 || bus.RspTag !== 4'd5 || bus.RspProd !== 128'd110) $display("FAIL bp_second got v %0b id %0b tag %0d prod %h exp 1 1 5 110", bus.RspValid, bus.RspId, bus.RspTag, bus.RspProd); else passed++;
      @(negedge clk);
   endtask

   task automatic test_kill();
      do_reset();
      @(negedge clk);
      bus.RspReady  = 1'b0;
      bus.ReqValid  = 2'b01;
      bus.ReqSrcA   = {64'd8, 64'd4};
      bus.ReqSrcB   = {64'd9, 64'd5};
      bus.ReqFunct3 = 6'b000_000;
      bus.ReqTag    = {4'd7, 4'd6};
      @(negedge clk);
      bus.ReqValid = 2'b11;
      bus.Kill     = 1'b1;
      #1;
      total++; if (MulFlushM !== 1'b1) $display("FAIL kill_flush got %0b exp 1", MulFlushM); else passed++;
      total++; if (bus.RspValid !== 1'b0) $display("FAIL kill_rspvalid got %0b exp 0", bus.RspValid); else passed++;
      total++; if (bus.ReqReady !== 2'b00) $display("FAIL kill_reqready got %b exp 00", bus.ReqReady); else passed++;
      total++; if (MulStallM !== 1'b0) $display("FAIL kill_stall got %0b exp 0", MulStallM); else passed++;
      @(negedge clk);
      bus.Kill     = 1'b0;
      bus.RspReady = 1'b1;
      #1;
      total++; if (bus.RspValid !== 1'b0) $display("FAIL kill_no_rsp got %0b exp 0", bus.RspValid); else passed++;
      // Pointer still favours requester 1 from the earlier accept.
      total++; if (bus.ReqReady !== 2'b10) $display("FAIL kill_prio got %b exp 10", bus.ReqReady); else passed++;
      @(negedge clk);
      bus.ReqValid = 2'b00;
      #1;
      total++; if (bus.RspValid !== 1'b1 || bus.RspId !== 1'b1 || bus.RspTag !== 4'd7 || bus.RspProd !== 128'd72) $display("FAIL kill_next got v %0b id %0b tag %0d prod %h exp 1 1 7 72", bus.RspValid, bus.RspId, bus.RspTag, bus.RspProd); else passed++;
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      do_reset();
      @(negedge clk);
      bus.RspReady  = 1'b0;
      bus.ReqValid  = 2'b01;
      bus.ReqSrcA   = {64'd2, 64'd2};
      bus.ReqSrcB   = {64'd2, 64'd2};
      bus.ReqFunct3 = 6'b000_000;
      bus.ReqTag    = {4'd4, 4'd8};
      @(negedge clk);
      bus.ReqValid = 2'b11;
      #1;
      total++; if (MulStallM !== 1'b1) $display("FAIL areset_pre_stall got %0b exp 1", MulStallM); else passed++;
      #2 reset = 1'b1;
      #1;
      total++; if (bus.RspValid !== 1'b0) $display("FAIL areset_rspvalid got %0b exp 0", bus.RspValid); else passed++;
      total++; if (bus.ReqReady !== 2'b00 && bus.ReqReady !== 2'b01) $display("FAIL areset_reqready got %b exp 00/01", bus.ReqReady); else passed++;
      total++; if (MulStallM !== 1'b0) $display("FAIL areset_stall got %0b exp 0", MulStallM); else passed++;
      @(negedge clk);
      reset        = 1'b0;
      bus.RspReady = 1'b1;
      #1;
      total++; if (bus.ReqReady !== 2'b01) $display("FAIL areset_prio got %b exp 01", bus.ReqReady); else passed++;
      @(negedge clk);
      bus.ReqValid = 2'b00;
      #1;
      total++; if (bus.RspValid !== 1'b1 || bus.RspId !== 1'b0 || bus.RspTag !== 4'd8) $display("FAIL areset_after got v %0b id %0b tag %0d exp 1 0 8", bus.RspValid, bus.RspId, bus.RspTag); else passed++;
      @(negedge clk);
   endtask

   task automatic test_req1_alone();
      do_reset();
      @(negedge clk);
      bus.RspReady  = 1'b1;
      bus.ReqValid  = 2'b10;
      bus.ReqSrcA   = {64'hFFFF_FFFF_FFFF_FFFF, 64'd3};
      bus.ReqSrcB   = {64'd2, 64'd3};
      bus.ReqFunct3 = 6'b010_000;
      bus.ReqTag    = {4'hA, 4'h1};
      #1;
      total++; if (bus.ReqReady !== 2'b10) $display("FAIL r1_reqready got %b exp 10", bus.ReqReady); else passed++;
      total++; if (MulSrcAE !== 64'hFFFF_FFFF_FFFF_FFFF || MulSrcBE !== 64'd2 || MulFunct3E !== 3'b010) $display("FAIL r1_select got a %h b %h f %b", MulSrcAE, MulSrcBE, MulFunct3E); else passed++;
      @(negedge clk);
      bus.ReqValid = 2'b00;
      #1;
      total++; if (bus.RspValid !== 1'b1 || bus.RspId !== 1'b1 || bus.RspTag !== 4'hA) $display("FAIL r1_rsp got v %0b id %0b tag %h exp 1 1 a", bus.RspValid, bus.RspId, bus.RspTag); else passed++;
      total++; if (bus.RspProd !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE}) $display("FAIL r1_prod got %h exp ffff...fffe", bus.RspProd); else passed++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_kill();
      test_async_reset();
      test_req1_alone();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mul_arb.md
Name: mul_arb

Overview:
- Round-robin arbiter and sequencer sharing one two-stage pipelined integer multiplier between two requesters, e.g. the integer pipeline MDU port and a coprocessor/accelerator port.
- Captures one request per cycle and drives the multiplier's execute-stage operands, Funct3 and Stall/Flush controls.
- Tracks the in-flight operation's owner and tag, and presents the double-width product on a valid/ready response channel.
- Backpressure freezes the multiplier pipeline register instead of discarding results.

Parameters:
- XLEN, 64, operand width; product is 2*XLEN.
- TAGW, 4, width of the requester-supplied transaction tag.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ReqValid  in  2  per-requester request valid; index 0 is the integer pipeline, index 1 the coprocessor
- ReqReady  out  2  per-requester accept; a transfer occurs when ReqValid[i] & ReqReady[i]
- ReqSrcA  in  2*XLEN  operand A, requester i in bits [i*XLEN +: XLEN]
- ReqSrcB  in  2*XLEN  operand B, same packing
- ReqFunct3  in  6  multiply type, requester i in bits [i*3 +: 3]
- ReqTag  in  2*TAGW  transaction tag, same packing
- Kill  in  1  abort the in-flight (M-stage) operation
- MulSrcAE  out  XLEN  operand A to the multiplier
- MulSrcBE  out  XLEN  operand B to the multiplier
- MulFunct3E  out  3  multiply type to the multiplier
- MulStallM  out  1  holds the multiplier M-stage registers
- MulFlushM  out  1  clears the multiplier M-stage registers
- MulProdM  in  2*XLEN  product from the multiplier M-stage
- RspValid  out  1  response valid
- RspReady  in  1  response accept
- RspId  out  1  owning requester
- RspTag  out  TAGW  tag of the owning request
- RspProd  out  2*XLEN  product, equal to MulProdM

Behaviour:
- State: MValid (op in M stage), MId, MTag, Prio (round-robin pointer).
- Reset values: MValid=0, MId=0, MTag=0, Prio=0 (requester 0 favoured first).
- Reset outputs: RspValid=0, ReqReady=00, MulStallM=0, MulFlushM=0.
- Reset asserted mid-operation discards the in-flight op; nothing is replayed.
- Issue slot free when: SlotFree = ~MValid | (RspValid & RspReady).
- Grant selection:
  - only one requester valid: grant it;
  - both valid: grant Prio;
  - ReqReady[g] = SlotFree & ~Kill for the granted index only; ReqReady is never 2'b11.
- Operand mux: MulSrcAE/BE/Funct3E come from the granted requester.
  - With no grant, mux select is held at index 0; no-grant operand values are don't-care for the datapath, but the bench checks the select.
- On accepted request at edge N:
  - MValid<=1, MId<=g, MTag<=tag;
  - Prio<=~g, so the other requester wins the next tie;
  - product valid on RspProd in cycle N+1 (latency 1 cycle after accept).
- Throughput is one op per cycle when RspReady is held high: the response and a new accept occur in the same cycle.
- MulStallM = MValid & ~RspReady & ~Kill, which freezes the partial-product registers while a response is pending.
- RspValid = MValid & ~Kill. RspId=MId, RspTag=MTag, RspProd=MulProdM.
- Response with no new accept: MValid<=0; MulStallM=0. The multiplier may then load don't-care operands, which is harmless because MValid=0.
- Kill:
  - MulFlushM=Kill; MValid<=0; no response for the killed op;
  - ReqReady=00 in the Kill cycle, and Prio is unchanged.
- Kill with MValid=0 is a no-op apart from MulFlushM pulsing.
- Idle requester: a requester that deasserts ReqValid before acceptance loses nothing; Prio does not change without an accept.
- Starvation bound: with both requesters continuously valid and RspReady=1, grants alternate 0,1,0,1,…

Test Plan:
1. Reset, then requester 0 sends A=3, B=5, Funct3=000, tag=2 with RspReady=1 → next cycle RspValid=1, RspId=0, RspTag=2, RspProd=15; ReqReady[0]=1 in the issue cycle.
2. Both requesters continuously valid, RspReady=1, 6 cycles → grants 0,1,0,1,0,1; one response per cycle with matching Id/Tag; products correct for MULH (001) with A=-2, B=3 (high word all ones, low word -6).
3. Backpressure: issue op, hold RspReady=0 for 3 cycles → RspValid stays 1, MulStallM=1, ReqReady=00, RspProd stable; RspReady=1 → response taken and a pending request accepted the same cycle.
4. Kill while MValid=1 and RspReady=0 → MulFlushM=1, no response, ReqReady=00 that cycle; the next request completes normally.
5. Reset asserted asynchronously mid-stall → RspValid, ReqReady, MulStallM drop immediately; after release Prio=0, so a tie grants requester 0.
6. Requester 1 alone with MULHSU (010), A=-1, B=2 → RspId=1, product high word 0xFFFF…FFFF, low word 0xFFFF…FFFE.
